// File: rtl/c3lib_ckmux_sel_ctl.sv
// ----------------------------------------------------------------------------
// c3lib_ckmux_sel_ctl
//
// Select sequencer for a 2-to-1 clock mux. An asynchronous select request is
// synchronised onto the free-running reference clock. Each accepted change is
// then carried out as a fixed sequence:
//   gate   : ck_en drops for GATE_DLY cycles while s0 still holds its value
//   switch : s0 takes the new select value
//   settle : ck_en stays low for SETTLE_DLY more cycles
//   ungate : ck_en returns high and sw_done pulses for one cycle
//   hold   : HOLD_DLY lock-out cycles before the next request is accepted
// This way the logic after the clock gate never sees a runt pulse from the
// source change.
//
// Ports:
//   clk      in   free-running reference clock
//   rst      in   asynchronous active-high reset
//   sel_in   in   requested mux select (asynchronous level)
//   sel_lock in   synchronous; while high, no new switch is started
//   s0       out  registered mux select
//   ck_en    out  registered clock-gate enable after the mux, 1 = pass
//   busy     out  high while a sequence or the hold-off is in progress
//   sw_done  out  one-cycle pulse when ck_en re-asserts after a switch
// ----------------------------------------------------------------------------
module c3lib_ckmux_sel_ctl #(
    parameter int SYNC_STAGES = 2,
    parameter int GATE_DLY    = 4,
    parameter int SETTLE_DLY  = 8,
    parameter int HOLD_DLY    = 2,
    parameter int CNT_W       = 4,
    parameter bit RST_SEL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sel_in,
    input  logic sel_lock,
    output logic s0,
    output logic ck_en,
    output logic busy,
    output logic sw_done
);

    // Parameter legality. Anything outside these ranges breaks the
    // sequence timing or overflows the delay counter.
    localparam int MAX_DLY = (GATE_DLY > SETTLE_DLY)
                           ? ((GATE_DLY > HOLD_DLY) ? GATE_DLY : HOLD_DLY)
                           : ((SETTLE_DLY > HOLD_DLY) ? SETTLE_DLY : HOLD_DLY);

    generate
        if (SYNC_STAGES < 2 || GATE_DLY < 1 || SETTLE_DLY < 1 || HOLD_DLY < 0
            || CNT_W < 1 || (MAX_DLY - 1) > ((1 << CNT_W) - 1)) begin : g_bad_params
            $error("c3lib_ckmux_sel_ctl: illegal parameter combination");
        end
    endgenerate

    // Counter reload values. HOLD_DLY of 0 never loads the hold value, but
    // it must still be a legal constant.
    localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_DLY - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_DLY - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'((HOLD_DLY > 0) ? HOLD_DLY - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATE   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // sel_in synchroniser. Stage 0 samples the raw input; each later stage
    // samples the one before it. The last stage is the only consumer-facing
    // copy of the request.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sel_sync;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = sel_in;
            end else begin : g_chain
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_SEL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sel_sync = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             tgt_q,     tgt_d;
    logic             s0_q,      s0_d;
    logic             ck_en_q,   ck_en_d;
    logic             busy_q,    busy_d;
    logic             sw_done_q, sw_done_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tgt_d     = tgt_q;
        s0_d      = s0_q;
        ck_en_d   = ck_en_q;
        busy_d    = busy_q;
        sw_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ck_en_d = 1'b1;
                busy_d  = 1'b0;
                // The target is frozen here; later movement of sel_in cannot
                // alter a sequence once it has started.
                if ((sel_sync != s0_q) && !sel_lock) begin
                    tgt_d   = sel_sync;
                    cnt_d   = GATE_LD;
                    state_d = ST_GATE;
                    ck_en_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            ST_GATE: begin
                if (cnt_q == '0) begin
                    s0_d    = tgt_q;
                    cnt_d   = SETTLE_LD;
                    state_d = ST_SETTLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    ck_en_d   = 1'b1;
                    sw_done_d = 1'b1;
                    if (HOLD_DLY > 0) begin
                        cnt_d   = HOLD_LD;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                ck_en_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tgt_q     <= RST_SEL;
            s0_q      <= RST_SEL;
            ck_en_q   <= 1'b1;
            busy_q    <= 1'b0;
            sw_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tgt_q     <= tgt_d;
            s0_q      <= s0_d;
            ck_en_q   <= ck_en_d;
            busy_q    <= busy_d;
            sw_done_q <= sw_done_d;
        end
    end

    assign s0      = s0_q;
    assign ck_en   = ck_en_q;
    assign busy    = busy_q;
    assign sw_done = sw_done_q;

endmodule
